frame_capture_fifo: RTL

- Sits directly downstream of the address-indexed decode register bank (data_multiplex).
- On each newly decoded thermostat frame (rising edge of mux_valid), it sweeps the bank's address input and copies the frame's 13 meaningful bytes into a frame-granular FIFO.
- The microcontroller then reads buffered frames at its own pace through a byte-addressed read port with a pop handshake, so a frame is not lost when the next one begins decoding.

---
 rtl/frame_capture_fifo_pkg.sv | 34 +++
 rtl/frame_capture_fifo_frame_store.sv | 50 +++++
 rtl/frame_capture_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/frame_capture_fifo_pkg.sv
// rtl/frame_capture_fifo_pkg.sv - shared constants, capture state type and sweep helper
// Purpose: byte-address map of a decoded thermostat frame, sweep length and
//          capture FSM state encoding shared by the capture FIFO and its bench.
// Ports:   none (package).
package frame_capture_fifo_pkg;

    localparam logic [3:0] ADDR_ID0     = 4'd0;
    localparam logic [3:0] ADDR_ID1     = 4'd1;
    localparam logic [3:0] ADDR_ID2     = 4'd2;
    localparam logic [3:0] ADDR_ID3     = 4'd3;
    localparam logic [3:0] ADDR_ROOM_LO = 4'd4;
    localparam logic [3:0] ADDR_ROOM_HI = 4'd5;
    localparam logic [3:0] ADDR_SET_LO  = 4'd6;
    localparam logic [3:0] ADDR_SET_HI  = 4'd7;
    localparam logic [3:0] ADDR_STATE   = 4'd8;
    localparam logic [3:0] ADDR_TAIL1   = 4'd9;
    localparam logic [3:0] ADDR_TAIL2   = 4'd10;
    localparam logic [3:0] ADDR_TAIL3   = 4'd11;
    localparam logic [3:0] ADDR_STATUS  = 4'd15;

    localparam int SWEEP_LEN = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } capture_state_t;

    // Sweep order is 0..11 then jumps straight to STATUS; 12..14 carry nothing.
    function automatic logic [3:0] next_sweep_addr(input logic [3:0] addr);
        return (addr == ADDR_TAIL3) ? ADDR_STATUS : addr + 4'd1;
    endfunction

endpackage

// File: rtl/frame_capture_fifo_frame_store.sv
// rtl/frame_capture_fifo_frame_store.sv - frame-slot byte RAM, one write port, one registered read port
// Purpose: holds SLOTS frames of 16 bytes each, addressed as {slot, byte}.
// Ports:   clock, reset_n      - clock, async active-low reset (read register only)
//          wr_en/wr_slot/wr_byte/wr_data - single-byte synchronous write
//          pad_en              - zero bytes 12..14 of wr_slot in the same cycle
//          rd_slot/rd_byte     - read address, registered onto rd_data
//          rd_blank            - force the read register to 0x00 instead of RAM data
//          rd_data             - registered read byte
module frame_store #(
    parameter int SLOTS  = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [3:0]        wr_byte,
    input  logic [7:0]        wr_data,
    input  logic              pad_en,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [3:0]        rd_byte,
    input  logic              rd_blank,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [SLOTS*16];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_slot, wr_byte}] <= wr_data;
        end
        // Unswept addresses must read back as zero rather than stale bytes.
        if (pad_en) begin
            mem[{wr_slot, 4'd12}] <= 8'h00;
            mem[{wr_slot, 4'd13}] <= 8'h00;
            mem[{wr_slot, 4'd14}] <= 8'h00;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else if (rd_blank) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[{rd_slot, rd_byte}];
        end
    end

endmodule

// File: rtl/frame_capture_fifo.sv
// rtl/frame_capture_fifo.sv - captures decoded frames from the register bank into a frame FIFO
// Purpose: on each rising edge of mux_valid, sweeps the bank (0..11,15) into the
//          next free frame slot; the host reads the head frame by byte and pops it.
// Ports:   clock, reset_n                 - clock, async active-low reset
//          mux_address/mux_data/mux_valid - decode bank sweep interface
//          host_address/host_data/host_pop - head-frame read port and pop
//          frame_available, frame_count   - occupancy
//          overflow, abort, host_clear    - sticky status flags and their clear
module frame_capture_fifo
    import frame_capture_fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [3:0]       mux_address,
    input  logic [7:0]       mux_data,
    input  logic             mux_valid,
    input  logic [3:0]       host_address,
    output logic [7:0]       host_data,
    input  logic             host_pop,
    output logic             frame_available,
    output logic [PTR_W:0]   frame_count,
    output logic             overflow,
    output logic             abort,
    input  logic             host_clear
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    capture_state_t state, state_next;

    logic             mux_valid_q, mux_valid_prev, rise;
    // Pointers carry one extra lap bit into a store of 2*FIFO_DEPTH slots, so the
    // slot being swept never aliases a buffered frame, even when the FIFO is full.
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_next;
    logic [3:0]       addr_next;
    logic             sweep_wr, pad_en, pop_ok, full;
    logic             commit_ok, overflow_set, abort_set;

    assign rise = mux_valid_q & ~mux_valid_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = SWEEP;
            SWEEP:   if (!mux_valid_q) state_next = IDLE;
                     else if (mux_address == ADDR_STATUS) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sweep_wr     = (state == SWEEP) && mux_valid_q;
        abort_set    = (state == SWEEP) && !mux_valid_q;
        pad_en       = (state == IDLE) && rise;
        pop_ok       = host_pop && frame_available;
        full         = (frame_count == FULL_COUNT);
        // A pop in the commit cycle frees the slot, so a full FIFO still accepts.
        commit_ok    = (state == COMMIT) && (!full || pop_ok);
        overflow_set = (state == COMMIT) && full && !pop_ok;
        addr_next    = 4'd0;
        if (sweep_wr && mux_address != ADDR_STATUS) begin
            addr_next = next_sweep_addr(mux_address);
        end
        count_next = frame_count;
        case ({commit_ok, pop_ok})
            2'b10:   count_next = frame_count + 1'b1;
            2'b01:   count_next = frame_count - 1'b1;
            default: count_next = frame_count;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mux_valid_q     <= 1'b0;
            mux_valid_prev  <= 1'b0;
            mux_address     <= 4'd0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            frame_count     <= '0;
            frame_available <= 1'b0;
            overflow        <= 1'b0;
            abort           <= 1'b0;
        end else begin
            mux_valid_q     <= mux_valid;
            mux_valid_prev  <= mux_valid_q;
            mux_address     <= addr_next;
            frame_count     <= count_next;
            frame_available <= (count_next != '0);
            if (commit_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)    rd_ptr <= rd_ptr + 1'b1;
            // Set wins over a coincident clear.
            if (overflow_set)    overflow <= 1'b1;
            else if (host_clear) overflow <= 1'b0;
            if (abort_set)       abort <= 1'b1;
            else if (host_clear) abort <= 1'b0;
        end
    end

    frame_store #(
        .SLOTS  (2 * FIFO_DEPTH),
        .SLOT_W (PTR_W + 1)
    ) u_store (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (sweep_wr),
        .wr_slot  (wr_ptr),
        .wr_byte  (mux_address),
        .wr_data  (mux_data),
        .pad_en   (pad_en),
        .rd_slot  (rd_ptr),
        .rd_byte  (host_address),
        .rd_blank (!frame_available),
        .rd_data  (host_data)
    );

endmodule
